// File: rtl/ram_dev_if.sv
// Motherboard RAM port bundle: ctrl/addr/data_in request from the board, stat/data_out response.
interface ram_dev_if #(
  parameter int word_width = 32
);
  logic [word_width-1:0] ctrl;
  logic [word_width-1:0] stat;
  logic [word_width-1:0] addr;
  logic [word_width-1:0] data_in;
  logic [word_width-1:0] data_out;

  modport master (output ctrl, addr, data_in, input stat, data_out);
  modport slave  (input ctrl, addr, data_in, output stat, data_out);
endinterface

// File: rtl/ram_dev.sv
// Word-addressed RAM with programmable latency behind a four-phase ctrl/stat handshake.
// Optional RAM_ADDR_ERR_EN: out-of-range accesses complete with stat bit 31 set.
module ram_dev #(
  parameter int word_width = 32,
  parameter int DEPTH      = 1024,
  parameter int ADDR_BITS  = 10,
  parameter int LATENCY    = 2
) (
  input  logic     clk,
  input  logic     rst,
  ram_dev_if.slave bus
);

  localparam logic [word_width-1:0] CTRL_READ  = 'h1;
  localparam logic [word_width-1:0] CTRL_WRITE = 'h2;
  localparam logic [word_width-1:0] STAT_IDLE  = '0;
  localparam logic [word_width-1:0] STAT_DONE  = 'h1;
`ifdef RAM_ADDR_ERR_EN
  localparam logic [word_width-1:0] STAT_ERR   = {1'b1, {(word_width-1){1'b0}}};
`endif

  localparam int                CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0]  CNT_INIT = (LATENCY > 0) ? CNT_W'(LATENCY - 1) : '0;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;
  typedef enum logic [1:0] {OP_NOP, OP_READ, OP_WRITE} op_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  op_e                    op_q, op_d;
  logic [ADDR_BITS-1:0]   idx_q, idx_d;
  logic                   oor_q, oor_d;
  logic [word_width-1:0]  wdata_q, wdata_d;
  logic [word_width-1:0]  stat_q, stat_d;
  logic [word_width-1:0]  data_out_q, data_out_d;

  // NOTE: memory is deliberately left out of reset so it maps onto RAM macros;
  // the initialiser only gives simulation a defined zero start.
  logic [word_width-1:0]  mem_q [DEPTH] = '{default: '0};

  op_e                    req_op;
  logic [ADDR_BITS-1:0]   req_idx;
  logic                   req_oor;

  logic                   acc_en;
  op_e                    acc_op;
  logic [ADDR_BITS-1:0]   acc_idx;
  logic                   acc_oor;
  logic [word_width-1:0]  acc_wdata;
  logic                   mem_we;

  // Read wins when both bits are set, matching the motherboard decoder.
  always_comb begin
    if ((bus.ctrl & CTRL_READ) != '0)       req_op = OP_READ;
    else if ((bus.ctrl & CTRL_WRITE) != '0) req_op = OP_WRITE;
    else                                    req_op = OP_NOP;
  end

  assign req_idx = bus.addr[ADDR_BITS+1:2];
  assign req_oor = (bus.addr >> (ADDR_BITS + 2)) != '0;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    idx_d      = idx_q;
    oor_d      = oor_q;
    wdata_d    = wdata_q;
    stat_d     = stat_q;
    data_out_d = data_out_q;
    acc_en     = 1'b0;
    acc_op     = op_q;
    acc_idx    = idx_q;
    acc_oor    = oor_q;
    acc_wdata  = wdata_q;

    case (state_q)
      S_IDLE: begin
        if (bus.ctrl != '0) begin
          op_d    = req_op;
          idx_d   = req_idx;
          oor_d   = req_oor;
          wdata_d = bus.data_in;
          if (LATENCY == 0) begin
            // Zero latency: the access uses the live request on the accepting edge.
            acc_en    = 1'b1;
            acc_op    = req_op;
            acc_idx   = req_idx;
            acc_oor   = req_oor;
            acc_wdata = bus.data_in;
          end else begin
            state_d = S_BUSY;
            cnt_d   = CNT_INIT;
          end
        end
      end
      S_BUSY: begin
        if (cnt_q == '0) acc_en = 1'b1;
        else             cnt_d  = cnt_q - CNT_W'(1);
      end
      S_DONE: begin
        if (bus.ctrl == '0) begin
          state_d    = S_IDLE;
          stat_d     = STAT_IDLE;
          data_out_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (acc_en) begin
      state_d = S_DONE;
`ifdef RAM_ADDR_ERR_EN
      stat_d  = acc_oor ? (STAT_DONE | STAT_ERR) : STAT_DONE;
`else
      stat_d  = STAT_DONE;
`endif
      if (acc_op == OP_READ) data_out_d = acc_oor ? '0 : mem_q[acc_idx];
    end
  end

  // Reset must also block a zero-latency write presented while rst is held.
  assign mem_we = acc_en && (acc_op == OP_WRITE) && !acc_oor && !rst;

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      op_q       <= OP_NOP;
      idx_q      <= '0;
      oor_q      <= 1'b0;
      wdata_q    <= '0;
      stat_q     <= STAT_IDLE;
      data_out_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      idx_q      <= idx_d;
      oor_q      <= oor_d;
      wdata_q    <= wdata_d;
      stat_q     <= stat_d;
      data_out_q <= data_out_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[acc_idx] <= acc_wdata;
  end

  assign bus.stat     = stat_q;
  assign bus.data_out = data_out_q;

endmodule

// File: doc/ram_dev.md
Name: ram_dev

Overview:
- Memory device on the motherboard RAM port. It consumes the `ram_ctrl`/`addr`/`data_out` request issued by the motherboard and returns `ram_stat`/`data_in`.
- Implements word-addressed storage with a programmable access latency.
- Uses a four-phase ctrl/stat handshake with the `CTRL_*`/`STAT_*` encodings from `control_pins.v`.
- Serves as both the simulation RAM model and the synthesizable on-chip RAM.

Parameters:
- `word_width`, 32: width of ctrl, stat, addr and data.
- `DEPTH`, 1024: number of words stored (power of two).
- `ADDR_BITS`, 10: log2(DEPTH).
- `LATENCY`, 2: cycles spent in BUSY before completion; 0 is legal.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous active-high reset.
- `ctrl`  in  word_width  request from motherboard; `CTRL_READ`/`CTRL_WRITE` bits, 0 = no request.
- `stat`  out  word_width  `STAT_IDLE` or `STAT_DONE` (registered).
- `addr`  in  word_width  byte address; word index = `addr[ADDR_BITS+1:2]`.
- `data_in`  in  word_width  write data from motherboard.
- `data_out`  out  word_width  read data to motherboard (registered).

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst` is asynchronous and active-high.
- On reset: state=IDLE, `stat`=`STAT_IDLE`, `data_out`=0, latency counter=0, latched request cleared. Memory contents are not reset; the array is zero-initialised at time 0 for simulation.
- States: IDLE, BUSY, DONE.
- IDLE:
  - Stays in IDLE while `ctrl`==0.
  - On an edge with `ctrl`!=0:
    - Latch `addr`, `data_in` and op. READ if `ctrl & CTRL_READ`, else WRITE if `ctrl & CTRL_WRITE`.
    - Both bits set means READ (same priority as the motherboard decoder).
    - Neither bit set but `ctrl`!=0 means NOP: no access, but the request still completes.
  - If `LATENCY`>0: go to BUSY with counter=`LATENCY`-1. If `LATENCY`==0: perform the access and go to DONE on the same edge.
- BUSY:
  - Counter decrements each edge.
  - On the edge where counter==0: perform the access and go to DONE.
  - Inputs are ignored; the latched values are used.
  - `ctrl` dropping during BUSY does not abort. The access completes, DONE lasts one cycle, then the block returns to IDLE.
- Access:
  - WRITE: `mem[idx]` <= latched data.
  - READ: `data_out` <= `mem[idx]`.
  - Out-of-range address (`addr[word_width-1:ADDR_BITS+2]`!=0): write is dropped and read returns 0.
  - `addr[1:0]` is ignored (no unaligned access).
- DONE:
  - `stat`=`STAT_DONE`, `data_out` held.
  - While `ctrl`!=0: stay in DONE.
  - On an edge with `ctrl`==0: go to IDLE, `stat`=`STAT_IDLE`, `data_out`=0.
  - A new request is accepted only from IDLE, so a minimum of one idle cycle separates requests.
- Timing: if edge k is the first IDLE edge with `ctrl`!=0, `stat`==`STAT_DONE` after edge k+`LATENCY`. The write is visible to any later read.
- Reset mid-operation: returns to IDLE immediately. A write not yet committed (still in BUSY) is lost; a committed write is kept.
- `stat` and `data_out` change only on `clk` edges or on `rst`; there is no combinational path from inputs to outputs.

Optional Feature:
- Macro: `RAM_ADDR_ERR_EN`.
- Defined: an out-of-range access completes with `stat`=`STAT_DONE | 32'h8000_0000` (error flag, bit 31) instead of `STAT_DONE`. Read data is 0 and the write is dropped. The flag clears when the block returns to IDLE.
- Undefined: an out-of-range access completes silently with `STAT_DONE`.

Test Plan:
- Reset then idle: assert `rst` mid-cycle -> `stat`=`STAT_IDLE` and `data_out`=0 immediately, with no clock edge needed.
- Write/read round trip (`LATENCY`=2):
  - WRITE `addr`=0x10, `data_in`=0xDEADBEEF -> `STAT_DONE` 2 edges after acceptance.
  - Drop `ctrl` -> `STAT_IDLE`.
  - READ `addr`=0x10 -> `data_out`=0xDEADBEEF with `STAT_DONE`.
- Held handshake: keep `ctrl`=`CTRL_READ` for 10 cycles after DONE -> `stat` stays `STAT_DONE` and `data_out` stable. Exactly one access is performed, with no re-trigger.
- Priority and `LATENCY`=0:
  - `ctrl`=`CTRL_READ|CTRL_WRITE`, `addr`=0x10, `data_in`=0x1 -> read behaviour; `mem[4]` unchanged (0xDEADBEEF returned); DONE 1 cycle after request.
- Out of range: WRITE `addr`=0x1000 (`DEPTH`=1024), then READ `addr`=0x1000 -> read data 0 and `mem[0]` unchanged. With `RAM_ADDR_ERR_EN`, `stat` bit 31 is set.
- Reset mid-BUSY (`LATENCY`=4): WRITE 0x55 to `addr` 0x8, assert `rst` after 2 cycles -> a later READ of 0x8 returns its prior value (0).
